// File: rtl/multi_byte_addsub_seq_pkg.sv
// ---------------------------------------------------------------------------
// multi_byte_addsub_seq_pkg
//   Shared types and constants for the byte-serial add/subtract sequencer.
//   - state_e : sequencer states (IDLE=0, RUN=1, DONE=2)
//   - BYTE_W  : width of the shared adder datapath (8 bits)
// ---------------------------------------------------------------------------
package multi_byte_addsub_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : multi_byte_addsub_seq_pkg

// File: rtl/multi_byte_addsub_seq_if.sv
// ---------------------------------------------------------------------------
// multi_byte_addsub_seq_if
//   Request/response bundle between a controller and the sequencer.
//   Parameter NBYTES: operand width in bytes (W = 8*NBYTES).
//   Signals:
//     start, op_sub, a[W], b[W]                  controller -> sequencer
//     busy, done, result[W], carry_out, overflow sequencer  -> controller
//   Modports:
//     master : the requesting controller
//     slave  : the sequencer
// ---------------------------------------------------------------------------
interface multi_byte_addsub_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, carry_out, overflow
    );

endinterface : multi_byte_addsub_seq_if

// File: rtl/multi_byte_addsub_seq_adder.sv
// ---------------------------------------------------------------------------
// eightBitAdder
//   Shared 8-bit add/subtract core.
//   Ports:
//     a[8], b[8] : operands
//     Cin0       : carry into bit 0
//     subtract   : 1 inverts b inside the core (caller still supplies the
//                  carry-in used to complete the two's complement)
//     C7         : carry out of bit 7
//     sum[8]     : result byte
// ---------------------------------------------------------------------------
module eightBitAdder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       Cin0,
    input  logic       subtract,
    output logic       C7,
    output logic [7:0] sum
);

    logic [7:0] b_eff;
    logic [8:0] total;

    assign b_eff = b ^ {8{subtract}};
    assign total = {1'b0, a} + {1'b0, b_eff} + {8'd0, Cin0};
    assign sum   = total[7:0];
    assign C7    = total[8];

endmodule : eightBitAdder

// File: rtl/multi_byte_addsub_seq.sv
// ---------------------------------------------------------------------------
// multi_byte_addsub_seq
//   Performs an NBYTES-wide add or subtract by running one byte per clock
//   through a single shared 8-bit adder, least-significant byte first, with
//   the carry chained through a register.
//
//   Parameter NBYTES (>= 2): operand width in bytes, W = 8*NBYTES.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : multi_byte_addsub_seq_if.slave
//             start/op_sub/a/b captured in IDLE; busy high during RUN;
//             done pulses one cycle with result/carry_out/overflow valid,
//             which then hold until the next completion.
//
//   Optional feature macro: ADDSUB_SEQ_OVERFLOW_EN
//     defined   -> overflow reports signed overflow of the last operation
//     undefined -> overflow is tied to 0
// ---------------------------------------------------------------------------
module multi_byte_addsub_seq
    import multi_byte_addsub_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multi_byte_addsub_seq_if.slave        bus
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [W-1:0]     a_q,         a_d;
    logic [W-1:0]     b_q,         b_d;       // already inverted for subtract
    logic             carry_q,     carry_d;
    logic [W-9:0]     work_q,      work_d;    // bytes committed so far
    logic [W-1:0]     result_q,    result_d;
    logic             carry_out_q, carry_out_d;

    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic [7:0]       add_sum;
    logic             add_co;
    logic [W-1:0]     shifted;

    // The top byte of the next working value is the sum being produced now.
    // On the last byte this is the complete result, so it is written straight
    // to the result register and the working register never needs the top byte.
    assign add_a   = a_q[int'(idx_q) * BYTE_W +: BYTE_W];
    assign add_b   = b_q[int'(idx_q) * BYTE_W +: BYTE_W];
    assign shifted = {add_sum, work_q};

    eightBitAdder u_adder (
        .a        (add_a),
        .b        (add_b),
        .Cin0     (carry_q),
        .subtract (1'b0),
        .C7       (add_co),
        .sum      (add_sum)
    );

`ifdef ADDSUB_SEQ_OVERFLOW_EN
    logic overflow_q, overflow_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        work_d      = work_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
        overflow_d  = overflow_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert b once here and seed
                    // the carry chain with 1.
                    a_d     = bus.a;
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub;
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                work_d  = shifted[W-1:BYTE_W];
                carry_d = add_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    result_d    = shifted;
                    carry_out_d = add_co;
`ifdef ADDSUB_SEQ_OVERFLOW_EN
                    overflow_d  = (a_q[W-1] == b_q[W-1]) &&
                                  (shifted[W-1] != a_q[W-1]);
`endif
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            work_q      <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            work_q      <= work_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
        end
    end

`ifdef ADDSUB_SEQ_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;

endmodule : multi_byte_addsub_seq

// File: tb/tb_multi_byte_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_multi_byte_addsub_seq
//   Directed, table-driven bench for multi_byte_addsub_seq with NBYTES=4,
//   plus hand-written sequences for reset, ignored start/inputs during
//   RUN/DONE, and back-to-back operation with start held high.
// ---------------------------------------------------------------------------
module tb_multi_byte_addsub_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

`ifdef ADDSUB_SEQ_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op_sub;
        logic [W-1:0] exp_result;
        logic         exp_carry;
        logic         exp_ovf;     // value when overflow logic is enabled
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multi_byte_addsub_seq_if #(.NBYTES(NBYTES)) bus ();

    multi_byte_addsub_seq #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] prev_result;
    vec_t         vecs [8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete operation: start is presented for exactly one edge, then
    // the bench watches busy/done/result on falling edges.
    task automatic run_op(input vec_t v, input int id);
        int   busy_cnt;
        int   lat;
        bit   got_done;
        logic exp_o;
        exp_o = v.exp_ovf & OVF_EN;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = v.a;
        bus.b      = v.b;
        bus.op_sub = v.op_sub;
        busy_cnt   = 0;
        lat        = 0;
        got_done   = 1'b0;
        for (int k = 1; k <= NBYTES + 3 && !got_done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble inputs after capture; they must have no effect.
                bus.start  = 1'b0;
                bus.a      = ~v.a;
                bus.b      = ~v.b;
                bus.op_sub = ~v.op_sub;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                lat      = k;
            end else begin
                check($sformatf("op%0d_result_held_k%0d", id, k), bus.result, prev_result);
            end
        end
        check($sformatf("op%0d_latency", id), W'(lat), W'(NBYTES + 1));
        check($sformatf("op%0d_busy_cycles", id), W'(busy_cnt), W'(NBYTES));
        check($sformatf("op%0d_result", id), bus.result, v.exp_result);
        check($sformatf("op%0d_carry_out", id), W'(bus.carry_out), W'(v.exp_carry));
        check($sformatf("op%0d_overflow", id), W'(bus.overflow), W'(exp_o));
        $display("op %0d: a=%h b=%h sub=%0d -> result=%h carry=%0d ovf=%0d latency=%0d busy=%0d",
                 id, v.a, v.b, v.op_sub, bus.result, bus.carry_out, bus.overflow, lat, busy_cnt);
        @(negedge clk);
        check($sformatf("op%0d_done_pulse_end", id), W'(bus.done), W'(0));
        check($sformatf("op%0d_result_after_done", id), bus.result, v.exp_result);
        prev_result = v.exp_result;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] seq_r  [3];
        logic         seq_c  [3];
        logic         seq_o  [3];
        int           ndone;
        logic         exp_busy;
        logic         exp_done;

        vecs[0] = '{32'h0000003E, 32'h00000003, 1'b0, 32'h00000041, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{32'h00000100, 32'h0000FF00, 1'b0, 32'h00010000, 1'b0, 1'b0};

        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        rst_n      = 1'b0;
        prev_result = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_busy",      W'(bus.busy),      W'(0));
        check("reset_done",      W'(bus.done),      W'(0));
        check("reset_result",    bus.result,        W'(0));
        check("reset_carry_out", W'(bus.carry_out), W'(0));
        check("reset_overflow",  W'(bus.overflow),  W'(0));
        $display("reset: busy=%0d done=%0d result=%h carry=%0d ovf=%0d",
                 bus.busy, bus.done, bus.result, bus.carry_out, bus.overflow);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven operations
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], i);
        end

        // Start held high through RUN and DONE with inputs changing: RUN/DONE
        // ignore everything, IDLE captures at T+6 and T+12.
        seq_r[0] = 32'h00000041; seq_c[0] = 1'b0; seq_o[0] = 1'b0;
        seq_r[1] = 32'hFFFFFFFE; seq_c[1] = 1'b0; seq_o[1] = 1'b0;
        seq_r[2] = 32'h7FFFFFFF; seq_c[2] = 1'b1; seq_o[2] = OVF_EN;
        ndone = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = 32'h0000003E;
        bus.b      = 32'h00000003;
        bus.op_sub = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            exp_busy = (c <= 16) && (((c - 1) % 6) < 4);
            exp_done = (c <= 17) && (((c - 1) % 6) == 4);
            check($sformatf("seq_busy_c%0d", c), W'(bus.busy), W'(exp_busy));
            check($sformatf("seq_done_c%0d", c), W'(bus.done), W'(exp_done));
            if (bus.done === 1'b1) begin
                if (ndone < 3) begin
                    check($sformatf("seq_result_%0d", ndone), bus.result, seq_r[ndone]);
                    check($sformatf("seq_carry_%0d", ndone), W'(bus.carry_out), W'(seq_c[ndone]));
                    check($sformatf("seq_ovf_%0d", ndone), W'(bus.overflow), W'(seq_o[ndone]));
                    prev_result = seq_r[ndone];
                end
                $display("seq done %0d at cycle %0d: result=%h carry=%0d ovf=%0d",
                         ndone, c, bus.result, bus.carry_out, bus.overflow);
                ndone++;
            end else begin
                check($sformatf("seq_result_held_c%0d", c), bus.result, prev_result);
            end
            if (c == 2) begin
                bus.a      = 32'h0000FFFF;
                bus.b      = 32'h00001234;
                bus.op_sub = 1'b1;
            end
            if (c == 5) begin
                bus.a      = 32'h00000005;
                bus.b      = 32'h00000007;
                bus.op_sub = 1'b1;
            end
            if (c == 7) begin
                bus.a = 32'h80000000;
                bus.b = 32'h00000001;
            end
            if (c == 13) bus.start = 1'b0;
        end
        check("seq_done_count", W'(ndone), W'(3));

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = 32'h00000011;
        bus.b      = 32'h00000022;
        bus.op_sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("midrun_busy_before", W'(bus.busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("midrun_busy",   W'(bus.busy),      W'(0));
        check("midrun_done",   W'(bus.done),      W'(0));
        check("midrun_result", bus.result,        W'(0));
        check("midrun_carry",  W'(bus.carry_out), W'(0));
        $display("midrun reset: busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
        @(negedge clk);
        rst_n = 1'b1;
        prev_result = '0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
            check($sformatf("post_reset_result_c%0d", c), bus.result, W'(0));
        end
        check("post_reset_no_done", W'(ndone), W'(0));

        // Recovery after reset
        run_op(vecs[3], 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_multi_byte_addsub_seq
